// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: I2C target with a small byte-addressed register file.
// SCL/SDA are synchronized into clk. Data bits are sampled on SCL rise, and
// SDA is only ever changed on SCL fall. Writes go through an auto-incrementing
// register pointer, and reads stream register contents MSB-first.
module i2c_slave_regs #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50,
   parameter int         NUM_REGS   = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        scl_in,
   input  logic                        sda_in,
   output logic                        sda_oe,
   output logic [NUM_REGS*8-1:0]       reg_q,
   output logic                        wr_valid,
   output logic [$clog2(NUM_REGS)-1:0] wr_addr,
   output logic [7:0]                  wr_data,
   output logic                        busy
);

   localparam int PW = $clog2(NUM_REGS);
   localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_ADDR      = 4'd1,
      ST_ADDR_ACK  = 4'd2,
      ST_PTR       = 4'd3,
      ST_PTR_ACK   = 4'd4,
      ST_WDATA     = 4'd5,
      ST_WDATA_ACK = 4'd6,
      ST_RDATA     = 4'd7,
      ST_RDATA_ACK = 4'd8,
      ST_IGNORE    = 4'd9
   } state_t;

   // synchronizer and history flops
   logic scl_meta_q, scl_meta_d, scl_sync_q, scl_sync_d, scl_hist_q, scl_hist_d;
   logic sda_meta_q, sda_meta_d, sda_sync_q, sda_sync_d, sda_hist_q, sda_hist_d;

   // protocol state
   state_t        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic          phase_q, phase_d;     // ACK slot: 0 = before drive/release, 1 = after
   logic          sda_oe_q, sda_oe_d;
   logic          wr_valid_q, wr_valid_d;
   logic [PW-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]    wr_data_q, wr_data_d;
   logic          busy_q, busy_d;
   logic [7:0]    regs_q [NUM_REGS];
   logic [7:0]    regs_d [NUM_REGS];

   logic       scl_rise_s, scl_fall_s, start_s, stop_s;
   logic [7:0] byte_s, rd_byte_s;

   assign scl_rise_s = scl_sync_q & ~scl_hist_q;
   assign scl_fall_s = ~scl_sync_q & scl_hist_q;
   assign start_s    = scl_sync_q & scl_hist_q & sda_hist_q & ~sda_sync_q;
   assign stop_s     = scl_sync_q & scl_hist_q & ~sda_hist_q & sda_sync_q;
   assign byte_s     = {shift_q[6:0], sda_sync_q};
   assign rd_byte_s  = regs_q[ptr_q];

   // Next values of the two-flop synchronizers and their history flops
   always_comb begin
      scl_meta_d = scl_in;
      scl_sync_d = scl_meta_q;
      scl_hist_d = scl_sync_q;
      sda_meta_d = sda_in;
      sda_sync_d = sda_meta_q;
      sda_hist_d = sda_sync_q;
   end

   // Protocol FSM: next state, bit shifting, register writes and SDA drive
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      ptr_d      = ptr_q;
      phase_d    = phase_q;
      sda_oe_d   = sda_oe_q;
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      regs_d     = regs_q;

      if (stop_s) begin
         state_d  = ST_IDLE;
         cnt_d    = 3'd0;
         phase_d  = 1'b0;
         sda_oe_d = 1'b0;
      end else if (start_s) begin
         state_d  = ST_ADDR;
         cnt_d    = 3'd0;
         phase_d  = 1'b0;
         sda_oe_d = 1'b0;
      end else begin
         case (state_q)
            ST_ADDR, ST_PTR, ST_WDATA: begin
               if (scl_rise_s) begin
                  shift_d = byte_s;
                  cnt_d   = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     phase_d = 1'b0;
                     if (state_q == ST_ADDR) begin
                        if (byte_s[7:1] == SLAVE_ADDR) begin
                           state_d = ST_ADDR_ACK;
                        end else begin
                           state_d = ST_IGNORE;
                        end
                     end else if (state_q == ST_PTR) begin
                        ptr_d   = byte_s[PW-1:0];
                        state_d = ST_PTR_ACK;
                     end else begin
                        regs_d[ptr_q] = byte_s;
                        wr_valid_d    = 1'b1;
                        wr_addr_d     = ptr_q;
                        wr_data_d     = byte_s;
                        ptr_d         = ptr_q + PTR_ONE;
                        state_d       = ST_WDATA_ACK;
                     end
                  end else begin
                     phase_d = phase_q;
                  end
               end else begin
                  shift_d = shift_q;
               end
            end
            ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
               // first fall pulls SDA low for the ACK, the next fall ends the slot
               if (scl_fall_s) begin
                  if (!phase_q) begin
                     sda_oe_d = 1'b1;
                     phase_d  = 1'b1;
                  end else begin
                     phase_d  = 1'b0;
                     cnt_d    = 3'd0;
                     sda_oe_d = 1'b0;
                     if (state_q == ST_ADDR_ACK && shift_q[0]) begin
                        sda_oe_d = ~rd_byte_s[7];
                        shift_d  = {rd_byte_s[6:0], 1'b0};
                        state_d  = ST_RDATA;
                     end else if (state_q == ST_ADDR_ACK) begin
                        state_d = ST_PTR;
                     end else begin
                        state_d = ST_WDATA;
                     end
                  end
               end else begin
                  phase_d = phase_q;
               end
            end
            ST_RDATA: begin
               if (scl_rise_s) begin
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     state_d = ST_RDATA_ACK;
                     phase_d = 1'b0;
                  end else begin
                     state_d = ST_RDATA;
                  end
               end else if (scl_fall_s) begin
                  sda_oe_d = ~shift_q[7];
                  shift_d  = {shift_q[6:0], 1'b0};
               end else begin
                  shift_d = shift_q;
               end
            end
            ST_RDATA_ACK: begin
               // release SDA, sample master ACK/NACK, then reload on the next fall
               if (scl_fall_s && !phase_q) begin
                  sda_oe_d = 1'b0;
               end else if (scl_rise_s && !phase_q) begin
                  ptr_d = ptr_q + PTR_ONE;
                  if (sda_sync_q) begin
                     state_d = ST_IGNORE;
                  end else begin
                     phase_d = 1'b1;
                  end
               end else if (scl_fall_s && phase_q) begin
                  sda_oe_d = ~rd_byte_s[7];
                  shift_d  = {rd_byte_s[6:0], 1'b0};
                  cnt_d    = 3'd0;
                  phase_d  = 1'b0;
                  state_d  = ST_RDATA;
               end else begin
                  phase_d = phase_q;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   // busy tracks the state the FSM is about to enter
   always_comb begin
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         scl_meta_q <= 1'b1;
         scl_sync_q <= 1'b1;
         scl_hist_q <= 1'b1;
         sda_meta_q <= 1'b1;
         sda_sync_q <= 1'b1;
         sda_hist_q <= 1'b1;
         state_q    <= ST_IDLE;
         cnt_q      <= 3'd0;
         shift_q    <= 8'h00;
         ptr_q      <= '0;
         phase_q    <= 1'b0;
         sda_oe_q   <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= 8'h00;
         busy_q     <= 1'b0;
         for (int k = 0; k < NUM_REGS; k++) begin
            regs_q[k] <= 8'h00;
         end
      end else begin
         scl_meta_q <= scl_meta_d;
         scl_sync_q <= scl_sync_d;
         scl_hist_q <= scl_hist_d;
         sda_meta_q <= sda_meta_d;
         sda_sync_q <= sda_sync_d;
         sda_hist_q <= sda_hist_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         ptr_q      <= ptr_d;
         phase_q    <= phase_d;
         sda_oe_q   <= sda_oe_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         busy_q     <= busy_d;
         for (int k = 0; k < NUM_REGS; k++) begin
            regs_q[k] <= regs_d[k];
         end
      end
   end

   // Flatten the register file onto reg_q
   always_comb begin
      reg_q = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         reg_q[8*k +: 8] = regs_q[k];
      end
   end

   assign sda_oe   = sda_oe_q;
   assign wr_valid = wr_valid_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb_i2c_slave_regs: bus-functional I2C master driving i2c_slave_regs.
// Stimulus pushes expectations into queues. A single monitor process pops
// them and compares against DUT outputs, bus observations and write pulses.
module tb_i2c_slave_regs;

   localparam int K_ACK    = 0;
   localparam int K_OE     = 1;
   localparam int K_BUSY   = 2;
   localparam int K_REGQ   = 3;
   localparam int K_WRV    = 4;
   localparam int K_MARK   = 5;
   localparam int K_OEDELT = 6;

   typedef struct {
      string       name;
      logic [31:0] exp;
      int          kind;
   } item_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        scl_m;
   logic        sda_m;
   logic        sda_bus;
   logic        sda_oe;
   logic [31:0] reg_q;
   logic        wr_valid;
   logic [1:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        busy;

   item_t      snap_q[$];
   item_t      bus_exp_q[$];
   logic [7:0] bus_obs_q[$];
   logic [9:0] wr_exp_q[$];

   int   checks   = 0;
   int   errors   = 0;
   int   viol_cnt = 0;
   int   oe_hi_cnt = 0;
   logic done = 1'b0;

   assign sda_bus = sda_m & ~sda_oe;

   always #5 clk = ~clk;

   i2c_slave_regs #(.SLAVE_ADDR(7'h50), .NUM_REGS(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .scl_in  (scl_m),
      .sda_in  (sda_bus),
      .sda_oe  (sda_oe),
      .reg_q   (reg_q),
      .wr_valid(wr_valid),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .busy    (busy)
   );

   // ---------------- master-side tasks ----------------
   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic snap(input int kind, input logic [31:0] e, input string nm);
      snap_q.push_back('{name: nm, exp: e, kind: kind});
   endtask

   task automatic send_bit(input logic b, output logic s);
      sda_m = b;
      wait_clk(5);
      scl_m = 1'b1;
      wait_clk(8);
      s = sda_bus;
      scl_m = 1'b0;
      wait_clk(5);
   endtask

   task automatic start_cond();
      sda_m = 1'b1;
      wait_clk(5);
      scl_m = 1'b1;
      wait_clk(8);
      sda_m = 1'b0;
      wait_clk(8);
      scl_m = 1'b0;
      wait_clk(5);
   endtask

   task automatic stop_cond();
      sda_m = 1'b0;
      wait_clk(5);
      scl_m = 1'b1;
      wait_clk(8);
      sda_m = 1'b1;
      wait_clk(8);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string nm);
      logic s;
      bus_exp_q.push_back('{name: nm, exp: {31'h0, exp_ack}, kind: K_ACK});
      for (int i = 7; i >= 0; i--) send_bit(b[i], s);
      send_bit(1'b1, s);
      bus_obs_q.push_back({7'h0, s});
   endtask

   task automatic recv_byte(input logic ack, input logic [7:0] e, input string nm);
      logic s;
      logic [7:0] r;
      r = 8'h00;
      bus_exp_q.push_back('{name: nm, exp: {24'h0, e}, kind: K_ACK});
      for (int i = 0; i < 8; i++) begin
         send_bit(1'b1, s);
         r = {r[6:0], s};
      end
      send_bit(ack, s);
      bus_obs_q.push_back(r);
   endtask

   // full write transaction of n (1 or 2) data bytes starting at ptr
   task automatic wr_txn(input logic [7:0] ptr, input logic [7:0] d0,
                         input logic [7:0] d1, input int n);
      logic [1:0] a;
      a = ptr[1:0];
      start_cond();
      send_byte(8'hA0, 1'b0, "wr_addr_ack");
      send_byte(ptr, 1'b0, "wr_ptr_ack");
      wr_exp_q.push_back({a, d0});
      send_byte(d0, 1'b0, "wr_d0_ack");
      if (n > 1) begin
         a = a + 2'd1;
         wr_exp_q.push_back({a, d1});
         send_byte(d1, 1'b0, "wr_d1_ack");
      end
      stop_cond();
      wait_clk(4);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic s;
      reset = 1'b1;
      scl_m = 1'b1;
      sda_m = 1'b1;
      wait_clk(3);
      reset = 1'b0;
      wait_clk(1);
      snap(K_OE,   32'h0, "reset_sda_oe");
      snap(K_BUSY, 32'h0, "reset_busy");
      snap(K_REGQ, 32'h0, "reset_reg_q");
      snap(K_WRV,  32'h0, "reset_wr_valid");
      wait_clk(4);

      // single write: reg2 = 0x5A
      start_cond();
      snap(K_BUSY, 32'h1, "busy_after_start");
      send_byte(8'hA0, 1'b0, "t1_addr_ack");
      send_byte(8'h02, 1'b0, "t1_ptr_ack");
      wr_exp_q.push_back({2'd2, 8'h5A});
      send_byte(8'h5A, 1'b0, "t1_data_ack");
      stop_cond();
      wait_clk(4);
      snap(K_REGQ, 32'h005A_0000, "t1_reg_q");
      snap(K_BUSY, 32'h0, "t1_busy_after_stop");

      // burst write wrapping from reg3 to reg0
      wr_txn(8'h03, 8'h11, 8'h22, 2);
      snap(K_REGQ, 32'h115A_0022, "t2_reg_q_wrap");

      // preload reg1/reg2 then read them back via repeated START
      wr_txn(8'h01, 8'hC3, 8'h96, 2);
      snap(K_REGQ, 32'h1196_C322, "t3_reg_q_preload");
      start_cond();
      send_byte(8'hA0, 1'b0, "t3_addr_w_ack");
      send_byte(8'h01, 1'b0, "t3_ptr_ack");
      start_cond();
      send_byte(8'hA1, 1'b0, "t3_addr_r_ack");
      recv_byte(1'b0, 8'hC3, "t3_read_reg1");
      recv_byte(1'b1, 8'h96, "t3_read_reg2");
      wait_clk(2);
      snap(K_OE, 32'h0, "t3_oe_after_nack");
      stop_cond();
      wait_clk(4);
      snap(K_BUSY, 32'h0, "t3_busy_after_stop");

      // address mismatch: no ACK, no write
      snap(K_MARK, 32'h0, "t4_mark");
      start_cond();
      send_byte(8'hA2, 1'b1, "t4_addr_nack");
      send_byte(8'hFF, 1'b1, "t4_data_nack");
      stop_cond();
      wait_clk(4);
      snap(K_OEDELT, 32'h0, "t4_oe_never_high");
      snap(K_REGQ, 32'h1196_C322, "t4_reg_q_unchanged");
      snap(K_BUSY, 32'h0, "t4_busy_after_stop");

      // reset in the middle of a data byte, then a fresh write
      start_cond();
      send_byte(8'hA0, 1'b0, "t5_addr_ack");
      send_byte(8'h00, 1'b0, "t5_ptr_ack");
      send_bit(1'b1, s);
      send_bit(1'b0, s);
      send_bit(1'b1, s);
      send_bit(1'b0, s);
      reset = 1'b1;
      wait_clk(1);
      reset = 1'b0;
      snap(K_OE,   32'h0, "t5_oe_after_reset");
      snap(K_REGQ, 32'h0, "t5_reg_q_after_reset");
      snap(K_BUSY, 32'h0, "t5_busy_after_reset");
      wait_clk(2);
      stop_cond();
      wait_clk(4);
      wr_txn(8'h01, 8'h77, 8'h00, 1);
      snap(K_REGQ, 32'h0000_7700, "t5_reg_q_rewrite");

      wait_clk(6);
      done = 1'b1;
   end

   // ---------------- SDA-vs-SCL watcher ----------------
   initial begin
      logic oe_prev;
      logic scl_prev;
      oe_prev  = 1'b0;
      scl_prev = 1'b1;
      forever begin
         @(posedge clk);
         if (sda_oe !== oe_prev && scl_prev === 1'b1) viol_cnt++;
         if (sda_oe === 1'b1) oe_hi_cnt++;
         oe_prev  = sda_oe;
         scl_prev = scl_m;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] e);
      checks++;
      if (act !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, e);
      end
   endtask

   initial begin
      item_t      it;
      logic [7:0] obs;
      logic [9:0] w;
      int         oe_base;
      oe_base = 0;
      forever begin
         @(negedge clk);
         while (snap_q.size() > 0) begin
            it = snap_q.pop_front();
            case (it.kind)
               K_OE:     chk(it.name, {31'h0, sda_oe}, it.exp);
               K_BUSY:   chk(it.name, {31'h0, busy}, it.exp);
               K_REGQ:   chk(it.name, reg_q, it.exp);
               K_WRV:    chk(it.name, {31'h0, wr_valid}, it.exp);
               K_MARK:   oe_base = oe_hi_cnt;
               K_OEDELT: chk(it.name, 32'(oe_hi_cnt - oe_base), it.exp);
               default:  chk("bad_item_kind", 32'(it.kind), 32'h0);
            endcase
         end
         while (bus_exp_q.size() > 0 && bus_obs_q.size() > 0) begin
            it  = bus_exp_q.pop_front();
            obs = bus_obs_q.pop_front();
            chk(it.name, {24'h0, obs}, it.exp);
         end
         if (wr_valid === 1'b1) begin
            if (wr_exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL wr_unexpected: got addr %0d data %h expected no write", wr_addr, wr_data);
            end else begin
               w = wr_exp_q.pop_front();
               chk("wr_event", {22'h0, wr_addr, wr_data}, {22'h0, w});
            end
         end
         if (done) begin
            chk("wr_queue_drained", 32'(wr_exp_q.size()), 32'h0);
            chk("bus_queue_drained", 32'(bus_exp_q.size()), 32'h0);
            chk("oe_change_while_scl_high", 32'(viol_cnt), 32'h0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
